// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    // Frame sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_addsub_fulladder.sv
// One-bit full-adder cell: s = a ^ b ^ y, c = majority(a, b, y).
module serial_addsub_fulladder (
    input  logic a,
    input  logic b,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ y;
    assign c = (a & b) | (y & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first adder/subtractor. A single full-adder cell and a
// carry flop process one bit per cycle; the parallel result, carry-out and
// signed overflow are published once per completed frame.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             a,
    input  logic             b,
    output logic             s,
    output logic             c,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // cnt holds (frame cycle - 1) while running, so cnt == WIDTH-1 marks the
    // cycle right after the last bit: the done cycle, where a new start may
    // chain straight into the next frame.
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q;
    logic             mode_q;
    logic [WIDTH-1:0] shreg_q;

    logic             mode_eff;
    logic             cin;
    logic             b_eff;
    logic             sum;
    logic             cout;
    logic             proc;
    logic             last;

    // Signed overflow of the MSB column: carry into it differs from carry out.
    function automatic logic signed_ovf(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

    // Bit 0 of a frame takes its mode and carry-in from the live sub input;
    // later bits use the latched mode and the carry flop.
    assign mode_eff = start ? sub : mode_q;
    assign cin      = start ? sub : carry_q;
    assign b_eff    = b ^ mode_eff;

    serial_addsub_fulladder u_fa (
        .a (a),
        .b (b_eff),
        .y (cin),
        .s (sum),
        .c (cout)
    );

    // A bit is consumed on a start, or while running up to the last bit.
    assign proc = start | ((state_q == ST_RUN) & (cnt_q != DONE_CNT));
    assign last = (state_q == ST_RUN) & ~start & (cnt_q == LAST_CNT);

    // Next-state, counter and busy decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                busy = ~((cnt_q == DONE_CNT) & ~start);
                if (start) begin
                    cnt_d = '0;
                end else if (cnt_q == DONE_CNT) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bit-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial datapath: sum bit, carry, mode latch and result shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s       <= 1'b0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            shreg_q <= '0;
        end else begin
            if (start) begin
                mode_q <= sub;
            end
            if (proc) begin
                s       <= sum;
                carry_q <= cout;
                shreg_q <= {sum, shreg_q[WIDTH-1:1]};
            end
        end
    end

    // Frame completion: publish result/flags and pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
            c      <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                result <= {sum, shreg_q[WIDTH-1:1]};
                c      <= cout;
                ovf    <= signed_ovf(cin, cout);
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH = 8).
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sub;
    logic       a;
    logic       b;
    logic       s;
    logic       c;
    logic       ovf;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .s      (s),
        .c      (c),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the rising edge, then wait to the
    // falling edge so the caller observes that cycle's outputs.
    task automatic step(input logic st, input logic sb, input logic aa, input logic bb);
        @(posedge clk);
        #1;
        start = st;
        sub   = sb;
        a     = aa;
        b     = bb;
        @(negedge clk);
    endtask

    // One isolated frame plus idle tail; sub is inverted after cycle 0 so the
    // mode must come from the latch.
    task automatic run_frame(input logic [7:0] av, input logic [7:0] bv, input logic sb,
                             output logic [7:0] sv, output int dcyc, output int dcnt,
                             output logic [11:0] bz, output logic [7:0] mid_res);
        sv = '0; dcyc = -1; dcnt = 0; bz = '0; mid_res = '0;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) step(k == 0, (k == 0) ? sb : ~sb, av[k], bv[k]);
            else       step(1'b0, 1'b0, 1'b0, 1'b0);
            if (k >= 1 && k <= 8) sv[k-1] = s;
            if (done === 1'b1) begin
                dcnt++;
                if (dcyc < 0) dcyc = k;
            end
            bz[k] = busy;
            if (k == 4) mid_res = result;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = 1'b0; b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s, c, ovf, busy, done, result} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got s=%b c=%b ovf=%b busy=%b done=%b result=%h expected all 0",
                     s, c, ovf, busy, done, result);
        end
        reset = 1'b0;
    endtask

    task automatic test_add;
        logic [7:0] sv, mr; logic [11:0] bz; int dc, dn;
        run_frame(8'h35, 8'h0A, 1'b0, sv, dc, dn, bz, mr);
        checks++; if (result !== 8'h3F) begin errors++; $display("FAIL add_result: got %h expected 3f", result); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL add_c: got %b expected 0", c); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b expected 0", ovf); end
        checks++; if (sv !== 8'h3F) begin errors++; $display("FAIL add_s_stream: got %h expected 3f", sv); end
        checks++; if (dc !== 8 || dn !== 1) begin errors++; $display("FAIL add_done: got cycle %0d count %0d expected cycle 8 count 1", dc, dn); end
        checks++; if (bz !== 12'h0FE) begin errors++; $display("FAIL add_busy: got %h expected 0fe", bz); end
        checks++; if (mr !== 8'h00) begin errors++; $display("FAIL add_mid_result: got %h expected 00", mr); end
    endtask

    task automatic test_carry;
        logic [7:0] sv, mr; logic [11:0] bz; int dc, dn; logic bad;
        run_frame(8'h7F, 8'h01, 1'b0, sv, dc, dn, bz, mr);
        checks++; if (result !== 8'h80 || c !== 1'b0 || ovf !== 1'b1) begin
            errors++; $display("FAIL carry_7f_01: got result=%h c=%b ovf=%b expected 80 0 1", result, c, ovf);
        end
        checks++; if (mr !== 8'h3F) begin errors++; $display("FAIL carry_mid_result: got %h expected 3f", mr); end
        // Idle: inputs must be ignored, s holds the last sum bit (1)
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, k[0], 1'b1, k[1]);
            if (s !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h80) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL idle_hold: got s=%b busy=%b done=%b result=%h expected 1 0 0 80", s, busy, done, result); end
        run_frame(8'hFF, 8'h01, 1'b0, sv, dc, dn, bz, mr);
        checks++; if (result !== 8'h00 || c !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL carry_ff_01: got result=%h c=%b ovf=%b expected 00 1 0", result, c, ovf);
        end
    endtask

    task automatic test_sub;
        logic [7:0] sv, mr; logic [11:0] bz; int dc, dn;
        run_frame(8'h10, 8'h20, 1'b1, sv, dc, dn, bz, mr);
        checks++; if (result !== 8'hF0 || c !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL sub_10_20: got result=%h c=%b ovf=%b expected f0 0 0", result, c, ovf);
        end
        checks++; if (sv !== 8'hF0) begin errors++; $display("FAIL sub_s_stream: got %h expected f0", sv); end
        run_frame(8'h80, 8'h01, 1'b1, sv, dc, dn, bz, mr);
        checks++; if (result !== 8'h7F || c !== 1'b1 || ovf !== 1'b1) begin
            errors++; $display("FAIL sub_80_01: got result=%h c=%b ovf=%b expected 7f 1 1", result, c, ovf);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a1, b1, a2, b2, r8, r12, r16;
        logic [19:0] dv, bz;
        logic aa, bb;
        a1 = 8'h12; b1 = 8'h34; a2 = 8'h55; b2 = 8'h0F;
        dv = '0; bz = '0; r8 = '0; r12 = '0; r16 = '0;
        for (int k = 0; k < 20; k++) begin
            if (k < 8)       begin aa = a1[k];   bb = b1[k];   end
            else if (k < 16) begin aa = a2[k-8]; bb = b2[k-8]; end
            else             begin aa = 1'b0;    bb = 1'b0;    end
            step(k == 0 || k == 8, 1'b0, aa, bb);
            dv[k] = done;
            bz[k] = busy;
            if (k == 8)  r8  = result;
            if (k == 12) r12 = result;
            if (k == 16) r16 = result;
        end
        checks++; if (dv !== 20'h10100) begin errors++; $display("FAIL b2b_done: got %h expected 10100", dv); end
        checks++; if (bz !== 20'h0FFFE) begin errors++; $display("FAIL b2b_busy: got %h expected 0fffe", bz); end
        checks++; if (r8 !== 8'h46 || r12 !== 8'h46) begin errors++; $display("FAIL b2b_first: got %h/%h expected 46/46", r8, r12); end
        checks++; if (r16 !== 8'h64) begin errors++; $display("FAIL b2b_second: got %h expected 64", r16); end
    endtask

    task automatic test_abort;
        logic [7:0] a1, b1, a2, b2, r8, r11;
        logic [13:0] dv, bz;
        logic aa, bb;
        a1 = 8'hAA; b1 = 8'h11; a2 = 8'h21; b2 = 8'h03;
        dv = '0; bz = '0; r8 = '0; r11 = '0;
        for (int k = 0; k < 14; k++) begin
            if (k < 3)       begin aa = a1[k];   bb = b1[k];   end
            else if (k < 11) begin aa = a2[k-3]; bb = b2[k-3]; end
            else             begin aa = 1'b0;    bb = 1'b0;    end
            step(k == 0 || k == 3, 1'b0, aa, bb);
            dv[k] = done;
            bz[k] = busy;
            if (k == 8)  r8  = result;
            if (k == 11) r11 = result;
        end
        checks++; if (dv !== 14'h0800) begin errors++; $display("FAIL abort_done: got %h expected 0800", dv); end
        checks++; if (bz !== 14'h07FE) begin errors++; $display("FAIL abort_busy: got %h expected 07fe", bz); end
        checks++; if (r8 !== 8'h64) begin errors++; $display("FAIL abort_hold: got %h expected 64", r8); end
        checks++; if (r11 !== 8'h24) begin errors++; $display("FAIL abort_result: got %h expected 24", r11); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] sv, mr; logic [11:0] bz; int dc, dn; logic bad;
        for (int k = 0; k < 6; k++) step(k == 0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if ({s, c, ovf, busy, done, result} !== 13'd0) begin
            errors++;
            $display("FAIL reset_midframe: got s=%b c=%b ovf=%b busy=%b done=%b result=%h expected all 0",
                     s, c, ovf, busy, done, result);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL reset_no_done: got done=%b busy=%b expected 0 0", done, busy); end
        run_frame(8'h35, 8'h0A, 1'b0, sv, dc, dn, bz, mr);
        checks++; if (result !== 8'h3F || dc !== 8) begin
            errors++; $display("FAIL reset_next_frame: got result=%h done cycle %0d expected 3f 8", result, dc);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
